// File: rtl/wave_sequencer.sv
// Waveform-selector sequencer: steps through the enabled selector codes of a latched mask,
// holding each for a latched dwell. Optional ROM address counter built when WAVESEQ_ROMADDR_EN is defined.
module wave_sequencer #(
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned ROM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [6:0]         seqMask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         waveSelector,
    output logic [ROM_AW-1:0]  romAddr,
    output logic               busy,
    output logic               passDone
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DWELL_W-1:0] DL_ONE  = DWELL_W'(1);
    localparam logic [2:0]         SEL_OFF = 3'b111;
    localparam logic [2:0]         SEL_ROM = 3'b110;

    state_t             state_q, state_d;
    logic [6:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dl_q, dl_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
    logic               expire;
    logic [2:0]         first_sel;
    logic [3:0]         nxt_cur, nxt_new;

    function automatic logic [2:0] lowest_set(input logic [6:0] m);
        lowest_set = SEL_OFF;
        for (int unsigned i = 7; i > 0; i--) begin
            if (m[i-1]) lowest_set = 3'(i - 1);
        end
    endfunction

    // {found, code} of the next enabled code strictly above s
    function automatic logic [3:0] next_higher(input logic [6:0] m, input logic [2:0] s);
        next_higher = 4'b0111;
        for (int unsigned i = 7; i > 0; i--) begin
            if (m[i-1] && ((i - 1) > 32'(s))) next_higher = {1'b1, 3'(i - 1)};
        end
    endfunction

    assign expire = (cnt_q == dl_q - DL_ONE);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        dl_d      = dl_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        pass_d    = 1'b0;
        first_sel = lowest_set(seqMask);
        nxt_cur   = next_higher(mask_q, sel_q);
        nxt_new   = 4'b0111;

        case (state_q)
            IDLE: begin
                if (start && !stop && (seqMask != '0)) begin
                    state_d = RUN;
                    mask_d  = seqMask;
                    dl_d    = (dwell == '0) ? DL_ONE : dwell;
                    cnt_d   = '0;
                    sel_d   = first_sel;
                    busy_d  = 1'b1;
                    nxt_new = next_higher(seqMask, first_sel);
                    pass_d  = (dl_d == DL_ONE) && !nxt_new[3];
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    sel_d   = SEL_OFF;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (expire) begin
                    cnt_d = '0;
                    if (!nxt_cur[3] && !loop) begin
                        state_d = IDLE;
                        sel_d   = SEL_OFF;
                        busy_d  = 1'b0;
                    end else begin
                        sel_d   = nxt_cur[3] ? nxt_cur[2:0] : lowest_set(mask_q);
                        nxt_new = next_higher(mask_q, sel_d);
                        pass_d  = (dl_q == DL_ONE) && !nxt_new[3];
                    end
                end else begin
                    cnt_d  = cnt_q + DL_ONE;
                    // passDone is registered, so it is raised on entry to the final dwell cycle
                    pass_d = (cnt_d == dl_q - DL_ONE) && !nxt_cur[3];
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = SEL_OFF;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            dl_q    <= '0;
            cnt_q   <= '0;
            sel_q   <= SEL_OFF;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dl_q    <= dl_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
        end
    end

`ifdef WAVESEQ_ROMADDR_EN
    logic [ROM_AW-1:0] rom_q, rom_d;

    always_comb begin
        rom_d = rom_q;
        if (busy_d) begin
            if ((state_q == IDLE) || expire) begin
                if (sel_d == SEL_ROM) rom_d = '0;
            end else if (sel_q == SEL_ROM) begin
                rom_d = rom_q + ROM_AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_q <= '0;
        end else begin
            rom_q <= rom_d;
        end
    end

    assign romAddr = rom_q;
`else
    assign romAddr = '0;
`endif

    assign waveSelector = sel_q;
    assign busy         = busy_q;
    assign passDone     = pass_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Scoreboard bench for wave_sequencer: a slot-list reference model queues expected outputs per cycle,
// a monitor pops and compares them. ROM address expectations follow WAVESEQ_ROMADDR_EN.
module tb_wave_sequencer;

    localparam int DW = 16;
    localparam int AW = 8;
`ifdef WAVESEQ_ROMADDR_EN
    localparam bit ROM_EN = 1'b1;
`else
    localparam bit ROM_EN = 1'b0;
`endif

    logic          clk = 1'b1;
    logic          rst;
    logic          start, stop, loop;
    logic [6:0]    seq_mask;
    logic [DW-1:0] dwell;
    logic [2:0]    wave_sel;
    logic [AW-1:0] rom_addr;
    logic          busy, pass_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int sel;
        int busy;
        int pd;
        int rom;
    } exp_t;

    exp_t exp_q[$];

    // reference model state: ordered list of enabled codes, current slot, elapsed cycles in slot
    bit m_run;
    int m_slots[$];
    int m_idx;
    int m_t;
    int m_d;
    int m_rom;

    wave_sequencer #(.DWELL_W(DW), .ROM_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .seqMask     (seq_mask),
        .dwell       (dwell),
        .waveSelector(wave_sel),
        .romAddr     (rom_addr),
        .busy        (busy),
        .passDone    (pass_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_rom = 0;
        m_idx = 0;
        m_t   = 0;
    endtask

    task automatic model_step(input bit r, input bit st, input bit sp, input bit lp,
                              input logic [6:0] mk, input int dw);
        exp_t e;
        if (!r) begin
            model_reset();
        end else if (!m_run) begin
            if (st && !sp && mk != 0) begin
                m_slots.delete();
                for (int i = 0; i < 7; i++) if (mk[i]) m_slots.push_back(i);
                m_d   = (dw == 0) ? 1 : dw;
                m_idx = 0;
                m_t   = 0;
                m_run = 1'b1;
                if (m_slots[0] == 6) m_rom = 0;
            end
        end else if (sp) begin
            m_run = 1'b0;
        end else begin
            m_t++;
            if (m_t == m_d) begin
                m_t = 0;
                m_idx++;
                if (m_idx == m_slots.size()) begin
                    m_idx = 0;
                    if (!lp) m_run = 1'b0;
                end
                if (m_run && m_slots[m_idx] == 6) m_rom = 0;
            end else if (m_slots[m_idx] == 6) begin
                m_rom = (m_rom + 1) % (1 << AW);
            end
        end
        e.sel  = m_run ? m_slots[m_idx] : 7;
        e.busy = m_run ? 1 : 0;
        e.pd   = (m_run && m_idx == m_slots.size() - 1 && m_t == m_d - 1) ? 1 : 0;
        e.rom  = ROM_EN ? m_rom : 0;
        exp_q.push_back(e);
    endtask

    // drive one cycle of inputs at the falling edge and queue the outputs expected after the next rise
    task automatic cyc(input bit r, input bit st, input bit sp, input bit lp,
                       input logic [6:0] mk, input int dw);
        @(negedge clk);
        rst      = r;
        start    = st;
        stop     = sp;
        loop     = lp;
        seq_mask = mk;
        dwell    = DW'(dw);
        model_step(r, st, sp, lp, mk, dw);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty at %0t: got no expectation, required one per cycle", $time);
            end else begin
                e = exp_q.pop_front();
                check("waveSelector", int'(wave_sel), e.sel);
                check("busy", int'(busy), e.busy);
                check("passDone", int'(pass_done), e.pd);
                check("romAddr", int'(rom_addr), e.rom);
            end
        end
    end

    initial begin
        logic [6:0] rm;
        rst = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; seq_mask = '0; dwell = '0;
        model_reset();

        repeat (3) cyc(0, 1, 0, 1, 7'h7f, 2);
        repeat (2) cyc(1, 0, 0, 0, 7'h00, 0);

        // two-slot pass, no loop
        cyc(1, 1, 0, 0, 7'b0000101, 3);
        repeat (9) cyc(1, 0, 0, 0, 7'b0000101, 3);

        // mask 0 start is ignored
        repeat (3) cyc(1, 1, 0, 1, 7'b0000000, 2);

        // dwell 0 behaves as 1, two codes toggle
        cyc(1, 1, 0, 1, 7'b0010010, 0);
        repeat (8) cyc(1, 0, 0, 1, 7'b0010010, 0);
        repeat (4) cyc(1, 0, 0, 0, 7'b0010010, 0);

        // single ROM slot with dwell longer than the address space
        cyc(1, 1, 0, 1, 7'b1000000, 300);
        repeat (700) cyc(1, $urandom_range(0, 1) == 1, 0, 1, 7'($urandom_range(0, 127)), 5);
        cyc(1, 0, 1, 1, 7'b1000000, 300);
        repeat (2) cyc(1, 0, 0, 1, 7'b1000000, 300);

        // stop sampled on the edge that would enter the pass-end cycle
        cyc(1, 1, 0, 1, 7'b0000011, 2);
        repeat (2) cyc(1, 0, 0, 1, 7'b0000011, 2);
        cyc(1, 0, 1, 1, 7'b0000011, 2);
        repeat (2) cyc(1, 0, 0, 1, 7'b0000011, 2);

        // start and stop together in IDLE
        cyc(1, 1, 1, 1, 7'h7f, 1);
        repeat (3) cyc(1, 0, 0, 1, 7'h7f, 1);

        // asynchronous reset between edges mid-slot
        cyc(1, 1, 0, 1, 7'b1000000, 5);
        repeat (3) cyc(1, 0, 0, 1, 7'b1000000, 5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_sel", int'(wave_sel), 7);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_pass", int'(pass_done), 0);
        check("async_rst_rom", int'(rom_addr), 0);
        cyc(0, 0, 0, 1, 7'b1000000, 5);
        repeat (5) cyc(1, 1, 0, 1, 7'b0000000, 5);
        repeat (3) cyc(1, 0, 0, 1, 7'b1000000, 5);

        // randomized traffic
        repeat (800) begin
            rm = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) rm = '0;
            cyc(1, $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 3) != 0, rm, $urandom_range(0, 4));
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
